// File: rtl/icache_if.sv
// Instruction-side bus between datapath, icache and memory controller.
// The cache is the slave; the bench (datapath plus memory) drives the master side.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only, one-word-per-frame instruction cache with single-word miss fill.
// Define ICACHE_STATS_EN to build the hit/miss counters; otherwise the count outputs are tied to 0.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  icache_if.slave     bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE, FILL} state_e;

  state_e          state_q, state_d;
  logic [31:0]     missAddr_q, missAddr_d;
  logic [SETS-1:0] valid_q;
  logic [TW-1:0]   tag_q  [SETS];
  logic [31:0]     data_q [SETS];

  logic [IW-1:0] reqIdx;
  logic [TW-1:0] reqTag;
  logic [IW-1:0] fillIdx;
  logic [TW-1:0] fillTag;
  logic          lookupHit;
  logic          fillDone;
  logic          unusedAddrBits;

  assign reqIdx         = bus.imemaddr[IW+1:2];
  assign reqTag         = bus.imemaddr[31:IW+2];
  assign fillIdx        = missAddr_q[IW+1:2];
  assign fillTag        = missAddr_q[31:IW+2];
  assign unusedAddrBits = ^bus.imemaddr[1:0];

  assign lookupHit = (state_q == IDLE) && bus.imemREN && valid_q[reqIdx]
                     && (tag_q[reqIdx] == reqTag);
  assign fillDone  = (state_q == FILL) && !bus.iwait;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      missAddr_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      missAddr_q <= missAddr_d;
      if (fillDone) valid_q[fillIdx] <= 1'b1;
    end
  end

  // Tag/data arrays need no reset: valid bits gate every read.
  always_ff @(posedge CLK) begin
    if (!RST && fillDone) begin
      tag_q[fillIdx]  <= fillTag;
      data_q[fillIdx] <= bus.iload;
    end
  end

  always_comb begin
    state_d      = state_q;
    missAddr_d   = missAddr_q;
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    case (state_q)
      IDLE: begin
        if (lookupHit) begin
          bus.ihit     = 1'b1;
          bus.imemload = data_q[reqIdx];
        end else if (bus.imemREN) begin
          missAddr_d = {bus.imemaddr[31:2], 2'b00};
          state_d    = FILL;
        end
      end
      FILL: begin
        bus.iREN  = 1'b1;
        bus.iaddr = missAddr_q;
        if (!bus.iwait) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hitCount_q;
  logic [31:0] missCount_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else begin
      if (lookupHit) hitCount_q <= hitCount_q + 32'd1;
      if (state_q == IDLE && state_d == FILL) missCount_q <= missCount_q + 32'd1;
    end
  end

  assign hit_count  = hitCount_q;
  assign miss_count = missCount_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache: drives datapath fetches and a scripted memory, checks each cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
module tb_icache;

`ifdef ICACHE_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        CLK;
  logic        RST;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic [31:0] expHit;
  logic [31:0] expMiss;
  int          compared;
  int          mismatched;

  icache_if bus ();

  icache #(.SETS(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus.slave),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic nextCycle;
    @(posedge CLK);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic applyStimulus(input logic ren, input logic [31:0] addr,
                               input logic wt, input logic [31:0] load);
    bus.imemREN  = ren;
    bus.imemaddr = addr;
    bus.iwait    = wt;
    bus.iload    = load;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0);
    nextCycle;
    nextCycle;
    RST = 1'b0;
    settle;
    compared++; if (bus.ihit !== 1'b0) begin mismatched++; $display("[TB] FAIL resetIhit: got %h expected 0", bus.ihit); end
    compared++; if (bus.imemload !== 32'h0) begin mismatched++; $display("[TB] FAIL resetImemload: got %h expected 0", bus.imemload); end
    compared++; if (bus.iREN !== 1'b0) begin mismatched++; $display("[TB] FAIL resetIREN: got %h expected 0", bus.iREN); end
    compared++; if (bus.iaddr !== 32'h0) begin mismatched++; $display("[TB] FAIL resetIaddr: got %h expected 0", bus.iaddr); end
    compared++; if (hit_count !== 32'h0) begin mismatched++; $display("[TB] FAIL resetHitCount: got %h expected 0", hit_count); end
    compared++; if (miss_count !== 32'h0) begin mismatched++; $display("[TB] FAIL resetMissCount: got %h expected 0", miss_count); end
  endtask

  task automatic test_cold_miss;
    nextCycle;
    applyStimulus(1'b1, 32'h40, 1'b1, 32'hDEADBEEF);
    settle;
    compared++; if (bus.ihit !== 1'b0) begin mismatched++; $display("[TB] FAIL coldMissIhit: got %h expected 0", bus.ihit); end
    compared++; if (bus.iREN !== 1'b0) begin mismatched++; $display("[TB] FAIL coldMissCycleIREN: got %h expected 0", bus.iREN); end
    expMiss++;
    for (int c = 1; c <= 3; c++) begin
      nextCycle;
      bus.iwait = (c < 3);
      bus.iload = (c == 3) ? 32'h8C010004 : 32'hDEADBEEF;
      settle;
      compared++; if (bus.iREN !== 1'b1) begin mismatched++; $display("[TB] FAIL coldFillIREN c%0d: got %h expected 1", c, bus.iREN); end
      compared++; if (bus.iaddr !== 32'h40) begin mismatched++; $display("[TB] FAIL coldFillIaddr c%0d: got %h expected 40", c, bus.iaddr); end
      compared++; if (bus.ihit !== 1'b0) begin mismatched++; $display("[TB] FAIL coldFillIhit c%0d: got %h expected 0", c, bus.ihit); end
    end
    nextCycle;
    bus.iwait = 1'b1;
    settle;
    compared++; if (bus.ihit !== 1'b1) begin mismatched++; $display("[TB] FAIL coldHitIhit: got %h expected 1", bus.ihit); end
    compared++; if (bus.imemload !== 32'h8C010004) begin mismatched++; $display("[TB] FAIL coldHitData: got %h expected 8c010004", bus.imemload); end
    compared++; if (bus.iREN !== 1'b0) begin mismatched++; $display("[TB] FAIL coldHitIREN: got %h expected 0", bus.iREN); end
    compared++; if (miss_count !== (StatsEn ? expMiss : 32'h0)) begin mismatched++; $display("[TB] FAIL coldMissCount: got %h expected %h", miss_count, StatsEn ? expMiss : 32'h0); end
    expHit++;
  endtask

  task automatic test_warm_hit;
    nextCycle;
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h0);
    settle;
    compared++; if (bus.ihit !== 1'b1) begin mismatched++; $display("[TB] FAIL warmIhit: got %h expected 1", bus.ihit); end
    compared++; if (bus.imemload !== 32'h8C010004) begin mismatched++; $display("[TB] FAIL warmData: got %h expected 8c010004", bus.imemload); end
    compared++; if (bus.iREN !== 1'b0) begin mismatched++; $display("[TB] FAIL warmIREN: got %h expected 0", bus.iREN); end
    compared++; if (hit_count !== (StatsEn ? expHit : 32'h0)) begin mismatched++; $display("[TB] FAIL warmHitCountBefore: got %h expected %h", hit_count, StatsEn ? expHit : 32'h0); end
    expHit++;
    nextCycle;
    bus.imemREN = 1'b0;
    settle;
    compared++; if (bus.ihit !== 1'b0) begin mismatched++; $display("[TB] FAIL noReqIhit: got %h expected 0", bus.ihit); end
    compared++; if (bus.imemload !== 32'h0) begin mismatched++; $display("[TB] FAIL noReqData: got %h expected 0", bus.imemload); end
    compared++; if (bus.iREN !== 1'b0) begin mismatched++; $display("[TB] FAIL noReqIREN: got %h expected 0", bus.iREN); end
    compared++; if (hit_count !== (StatsEn ? expHit : 32'h0)) begin mismatched++; $display("[TB] FAIL warmHitCountAfter: got %h expected %h", hit_count, StatsEn ? expHit : 32'h0); end
  endtask

  task automatic test_byte_offset;
    nextCycle;
    applyStimulus(1'b1, 32'h43, 1'b1, 32'h0);
    settle;
    compared++; if (bus.ihit !== 1'b1) begin mismatched++; $display("[TB] FAIL offsetIhit: got %h expected 1", bus.ihit); end
    compared++; if (bus.imemload !== 32'h8C010004) begin mismatched++; $display("[TB] FAIL offsetData: got %h expected 8c010004", bus.imemload); end
    expHit++;
  endtask

  task automatic test_conflict;
    nextCycle;
    applyStimulus(1'b1, 32'h80, 1'b1, 32'h0);
    settle;
    compared++; if (bus.ihit !== 1'b0) begin mismatched++; $display("[TB] FAIL conflictMissIhit: got %h expected 0", bus.ihit); end
    expMiss++;
    nextCycle;
    bus.iwait = 1'b0;
    bus.iload = 32'h11112222;
    settle;
    compared++; if (bus.iREN !== 1'b1) begin mismatched++; $display("[TB] FAIL conflictFillIREN: got %h expected 1", bus.iREN); end
    compared++; if (bus.iaddr !== 32'h80) begin mismatched++; $display("[TB] FAIL conflictFillIaddr: got %h expected 80", bus.iaddr); end
    nextCycle;
    bus.iwait = 1'b1;
    bus.iload = 32'h0;
    settle;
    compared++; if (bus.imemload !== 32'h11112222) begin mismatched++; $display("[TB] FAIL conflictHitData: got %h expected 11112222", bus.imemload); end
    compared++; if (miss_count !== (StatsEn ? expMiss : 32'h0)) begin mismatched++; $display("[TB] FAIL conflictMissCount: got %h expected %h", miss_count, StatsEn ? expMiss : 32'h0); end
    expHit++;
    nextCycle;
    bus.imemaddr = 32'h40;
    settle;
    compared++; if (bus.ihit !== 1'b0) begin mismatched++; $display("[TB] FAIL refetchMissIhit: got %h expected 0", bus.ihit); end
    expMiss++;
    nextCycle;
    bus.iwait = 1'b0;
    bus.iload = 32'h8C010004;
    settle;
    compared++; if (bus.iaddr !== 32'h40) begin mismatched++; $display("[TB] FAIL refetchFillIaddr: got %h expected 40", bus.iaddr); end
    nextCycle;
    bus.iwait = 1'b1;
    settle;
    compared++; if (bus.imemload !== 32'h8C010004) begin mismatched++; $display("[TB] FAIL refetchHitData: got %h expected 8c010004", bus.imemload); end
    expHit++;
  endtask

  task automatic test_redirect_back_to_back;
    nextCycle;
    applyStimulus(1'b1, 32'h100, 1'b1, 32'h0);
    settle;
    compared++; if (bus.ihit !== 1'b0) begin mismatched++; $display("[TB] FAIL redirMissIhit: got %h expected 0", bus.ihit); end
    expMiss++;
    nextCycle;
    bus.imemaddr = 32'h204;
    settle;
    compared++; if (bus.iaddr !== 32'h100) begin mismatched++; $display("[TB] FAIL redirIaddrHeld: got %h expected 100", bus.iaddr); end
    compared++; if (bus.ihit !== 1'b0) begin mismatched++; $display("[TB] FAIL redirFillIhit: got %h expected 0", bus.ihit); end
    nextCycle;
    bus.iwait = 1'b0;
    bus.iload = 32'hAAAA0100;
    settle;
    compared++; if (bus.iaddr !== 32'h100) begin mismatched++; $display("[TB] FAIL redirIaddrLast: got %h expected 100", bus.iaddr); end
    nextCycle;
    bus.iwait = 1'b1;
    bus.iload = 32'h0;
    settle;
    compared++; if (bus.iREN !== 1'b0) begin mismatched++; $display("[TB] FAIL gapIREN: got %h expected 0", bus.iREN); end
    compared++; if (bus.ihit !== 1'b0) begin mismatched++; $display("[TB] FAIL redirTargetMissIhit: got %h expected 0", bus.ihit); end
    expMiss++;
    nextCycle;
    bus.iwait = 1'b0;
    bus.iload = 32'hBBBB0204;
    settle;
    compared++; if (bus.iREN !== 1'b1) begin mismatched++; $display("[TB] FAIL secondFillIREN: got %h expected 1", bus.iREN); end
    compared++; if (bus.iaddr !== 32'h204) begin mismatched++; $display("[TB] FAIL secondFillIaddr: got %h expected 204", bus.iaddr); end
    nextCycle;
    bus.iwait = 1'b1;
    bus.iload = 32'h0;
    settle;
    compared++; if (bus.imemload !== 32'hBBBB0204) begin mismatched++; $display("[TB] FAIL redirTargetHitData: got %h expected bbbb0204", bus.imemload); end
    expHit++;
    nextCycle;
    bus.imemaddr = 32'h100;
    settle;
    compared++; if (bus.ihit !== 1'b1) begin mismatched++; $display("[TB] FAIL redirOldHitIhit: got %h expected 1", bus.ihit); end
    compared++; if (bus.imemload !== 32'hAAAA0100) begin mismatched++; $display("[TB] FAIL redirOldHitData: got %h expected aaaa0100", bus.imemload); end
    expHit++;
    compared++; if (miss_count !== (StatsEn ? expMiss : 32'h0)) begin mismatched++; $display("[TB] FAIL redirMissCount: got %h expected %h", miss_count, StatsEn ? expMiss : 32'h0); end
  endtask

  task automatic test_reset_mid_fill;
    nextCycle;
    applyStimulus(1'b1, 32'h300, 1'b1, 32'h0);
    settle;
    compared++; if (bus.ihit !== 1'b0) begin mismatched++; $display("[TB] FAIL rstFillMissIhit: got %h expected 0", bus.ihit); end
    nextCycle;
    RST = 1'b1;
    bus.iwait = 1'b0;
    bus.iload = 32'h33330300;
    settle;
    compared++; if (bus.iaddr !== 32'h300) begin mismatched++; $display("[TB] FAIL rstFillIaddr: got %h expected 300", bus.iaddr); end
    nextCycle;
    RST = 1'b0;
    bus.iwait = 1'b1;
    bus.iload = 32'h0;
    expHit  = 32'h0;
    expMiss = 32'h0;
    settle;
    compared++; if (bus.iREN !== 1'b0) begin mismatched++; $display("[TB] FAIL rstAbortIREN: got %h expected 0", bus.iREN); end
    compared++; if (bus.iaddr !== 32'h0) begin mismatched++; $display("[TB] FAIL rstAbortIaddr: got %h expected 0", bus.iaddr); end
    compared++; if (bus.ihit !== 1'b0) begin mismatched++; $display("[TB] FAIL rstNoFrameIhit: got %h expected 0", bus.ihit); end
    compared++; if (hit_count !== 32'h0) begin mismatched++; $display("[TB] FAIL rstHitCount: got %h expected 0", hit_count); end
    compared++; if (miss_count !== 32'h0) begin mismatched++; $display("[TB] FAIL rstMissCount: got %h expected 0", miss_count); end
    expMiss++;
    nextCycle;
    bus.iwait = 1'b0;
    bus.iload = 32'h33330300;
    settle;
    compared++; if (bus.iaddr !== 32'h300) begin mismatched++; $display("[TB] FAIL refillIaddr: got %h expected 300", bus.iaddr); end
    nextCycle;
    bus.iwait = 1'b1;
    bus.iload = 32'h0;
    settle;
    compared++; if (bus.imemload !== 32'h33330300) begin mismatched++; $display("[TB] FAIL refillHitData: got %h expected 33330300", bus.imemload); end
    compared++; if (miss_count !== (StatsEn ? expMiss : 32'h0)) begin mismatched++; $display("[TB] FAIL refillMissCount: got %h expected %h", miss_count, StatsEn ? expMiss : 32'h0); end
  endtask

  initial begin
    CLK        = 1'b0;
    RST        = 1'b1;
    expHit     = 32'h0;
    expMiss    = 32'h0;
    compared   = 0;
    mismatched = 0;
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0);
    test_reset;
    test_cold_miss;
    test_warm_hit;
    test_byte_offset;
    test_conflict;
    test_redirect_back_to_back;
    test_reset_mid_fill;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
